// File: rtl/ppe_wrr_arb.sv
// Weighted round-robin arbiter: rotating-priority search over registered
// requests, per-requester grant quantum, registered valid/ready grant output.
module ppe_wrr_arb #(
  parameter int WIDTH    = 8,
  parameter int LOG_W    = 3,
  parameter int WEIGHT_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          req,
  input  logic [WIDTH*WEIGHT_W-1:0] weight_cfg,
  output logic                      gnt_valid,
  input  logic                      gnt_ready,
  output logic [WIDTH-1:0]          gnt,
  output logic [LOG_W-1:0]          gnt_idx
);

  localparam logic [LOG_W:0]   WIDTH_L = (LOG_W+1)'(WIDTH);
  localparam logic [LOG_W-1:0] LAST    = LOG_W'(WIDTH-1);

  logic [WIDTH-1:0]      req_q;
  logic [2**LOG_W-1:0]   req_ext;
  logic [LOG_W-1:0]      ptr, ptr_next, ptr_eff;
  logic [WEIGHT_W-1:0]   used, used_next, w_sel;
  logic [WEIGHT_W:0]     quantum, base_inc;
  logic                  accept, load;
  logic [LOG_W:0]        cand;
  logic                  win_found;
  logic [LOG_W-1:0]      win_idx;
  logic [WIDTH-1:0]      win_onehot;

  assign accept  = gnt_valid & gnt_ready;
  assign load    = ~gnt_valid | gnt_ready;
  assign req_ext = (2**LOG_W)'(req_q);

  // Quantum accounting for the grant being accepted this cycle
  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (gnt_idx == LOG_W'(i)) w_sel = weight_cfg[i*WEIGHT_W +: WEIGHT_W];
    end
    quantum   = (w_sel == '0) ? (WEIGHT_W+1)'(1) : {1'b0, w_sel};
    base_inc  = (gnt_idx == ptr) ? ({1'b0, used} + (WEIGHT_W+1)'(1)) : (WEIGHT_W+1)'(1);
    ptr_next  = ptr;
    used_next = used;
    if (accept) begin
      if (base_inc >= quantum) begin
        ptr_next  = (gnt_idx == LAST) ? '0 : gnt_idx + LOG_W'(1);
        used_next = '0;
      end else begin
        ptr_next  = gnt_idx;
        used_next = base_inc[WEIGHT_W-1:0];
      end
    end
    // ptr_next already equals ptr when nothing is accepted
    ptr_eff = ptr_next;
  end

  // Circular first-set search of req_q starting at ptr_eff
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    cand       = '0;
    win_onehot = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      cand = {1'b0, ptr_eff} + (LOG_W+1)'(k);
      if (cand >= WIDTH_L) cand = cand - WIDTH_L;
      if (!win_found && req_ext[cand[LOG_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[LOG_W-1:0];
      end
    end
    for (int unsigned i = 0; i < WIDTH; i++) begin
      win_onehot[i] = win_found && (win_idx == LOG_W'(i));
    end
  end

  // Request sampling, pointer/quantum state and grant output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q     <= '0;
      ptr       <= '0;
      used      <= '0;
      gnt_valid <= 1'b0;
      gnt       <= '0;
      gnt_idx   <= '0;
    end else begin
      req_q <= req;
      ptr   <= ptr_next;
      used  <= used_next;
      if (load) begin
        gnt_valid <= win_found;
        gnt       <= win_onehot;
        gnt_idx   <= win_found ? win_idx : '0;
      end
    end
  end

endmodule

// File: tb/tb_ppe_wrr_arb.sv
// Self-checking bench for ppe_wrr_arb: directed scenarios plus randomized
// traffic, all checked cycle by cycle against a behavioural reference model.
module tb_ppe_wrr_arb;

  localparam int WIDTH    = 8;
  localparam int LOG_W    = 3;
  localparam int WEIGHT_W = 4;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [WIDTH-1:0]          req = '0;
  logic [WIDTH*WEIGHT_W-1:0] weight_cfg = '0;
  logic                      gnt_ready = 1'b0;
  logic                      gnt_valid;
  logic [WIDTH-1:0]          gnt;
  logic [LOG_W-1:0]          gnt_idx;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state (integers, spec-level arithmetic)
  int         m_ptr, m_used, m_idx;
  bit         m_valid;
  logic [7:0] m_req_q;

  ppe_wrr_arb #(.WIDTH(WIDTH), .LOG_W(LOG_W), .WEIGHT_W(WEIGHT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .weight_cfg(weight_cfg),
    .gnt_valid(gnt_valid), .gnt_ready(gnt_ready), .gnt(gnt), .gnt_idx(gnt_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_w(input int i, input int v);
    weight_cfg[i*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(v);
  endtask

  task automatic all_w(input int v);
    for (int i = 0; i < WIDTH; i++) set_w(i, v);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_used = 0; m_idx = 0; m_valid = 0; m_req_q = '0;
  endtask

  // One rising edge of the specified behaviour, using the inputs held before it
  task automatic model_step();
    int q, base;
    bit found;
    if (m_valid && gnt_ready) begin
      q    = int'(weight_cfg[m_idx*WEIGHT_W +: WEIGHT_W]);
      if (q == 0) q = 1;
      base = (m_idx == m_ptr) ? m_used : 0;
      if (base + 1 >= q) begin
        m_ptr  = (m_idx + 1) % WIDTH;
        m_used = 0;
      end else begin
        m_ptr  = m_idx;
        m_used = base + 1;
      end
    end
    if (!m_valid || gnt_ready) begin
      found = 0;
      for (int k = 0; k < WIDTH; k++) begin
        if (!found && m_req_q[(m_ptr + k) % WIDTH]) begin
          found = 1;
          m_idx = (m_ptr + k) % WIDTH;
        end
      end
      m_valid = found;
      if (!found) m_idx = 0;
    end
    m_req_q = req;
  endtask

  task automatic cycle(input logic [7:0] r, input bit rd);
    logic [7:0] exp_gnt;
    req = r;
    gnt_ready = rd;
    @(posedge clk);
    model_step();
    #1;
    exp_gnt = '0;
    if (m_valid) exp_gnt[m_idx] = 1'b1;
    chk("gnt_valid", gnt_valid, m_valid);
    chk("gnt", gnt, exp_gnt);
    chk("gnt_idx", gnt_idx, m_valid ? m_idx : 0);
  endtask

  // Asserts reset between edges, checks the asynchronous clear, then releases
  task automatic do_reset();
    #1;
    rst = 1'b1;
    req = '0;
    gnt_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", gnt_valid, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_idx", gnt_idx, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int wexp [8];
    int zexp [4];
    logic [7:0] r;

    // Full round-robin, all weights 1
    all_w(1);
    do_reset();
    for (int n = 0; n < 11; n++) begin
      cycle(8'hFF, 1'b1);
      if (n >= 1) chk("rr_idx", gnt_idx, (n - 1) % 8);
    end

    // Weighted quantum: requester 2 gets three grants per turn
    wexp = '{2, 2, 2, 3, 2, 2, 2, 3};
    do_reset();
    set_w(2, 3);
    cycle(8'h0C, 1'b1);
    for (int n = 0; n < 8; n++) begin
      cycle(8'h0C, 1'b1);
      chk("wrr_idx", gnt_idx, wexp[n]);
    end

    // Weight zero acts as one
    zexp = '{5, 6, 5, 6};
    do_reset();
    all_w(1);
    set_w(5, 0);
    cycle(8'h60, 1'b1);
    for (int n = 0; n < 4; n++) begin
      cycle(8'h60, 1'b1);
      chk("w0_idx", gnt_idx, zexp[n]);
    end

    // Dropout mid-quantum moves on to the next requester
    do_reset();
    all_w(1);
    set_w(1, 4);
    cycle(8'h06, 1'b1);
    cycle(8'h06, 1'b1);
    chk("drop_g1", gnt_idx, 1);
    cycle(8'h06, 1'b1);
    chk("drop_g2", gnt_idx, 1);
    cycle(8'h04, 1'b1);
    cycle(8'h04, 1'b1);
    chk("drop_next", gnt_idx, 2);

    // Latency from reset and backpressure hold
    do_reset();
    all_w(1);
    cycle(8'h10, 1'b1);
    chk("lat_v0", gnt_valid, 0);
    cycle(8'h10, 1'b1);
    chk("lat_v1", gnt_valid, 1);
    chk("lat_idx", gnt_idx, 4);
    for (int n = 0; n < 5; n++) begin
      cycle(8'h01, 1'b0);
      chk("stall_gnt", gnt, 8'h10);
    end
    cycle(8'h01, 1'b1);
    chk("after_stall", gnt_idx, 0);

    // Pointer wrap from 7 to 0
    do_reset();
    cycle(8'h80, 1'b1);
    cycle(8'h80, 1'b0);
    chk("wrap_7", gnt_idx, 7);
    cycle(8'h81, 1'b0);
    cycle(8'h81, 1'b1);
    chk("wrap_0", gnt_idx, 0);

    // Asynchronous reset while a grant is pending
    cycle(8'h81, 1'b0);
    chk("pre_rst_valid", gnt_valid, 1);
    do_reset();
    cycle(8'hFF, 1'b1);
    cycle(8'hFF, 1'b1);
    chk("post_rst_idx", gnt_idx, 0);

    // Randomized traffic, weights and occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 19) == 0)
        for (int i = 0; i < WIDTH; i++) set_w(i, $urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) do_reset();
      r = ($urandom_range(0, 1) == 0) ? 8'($urandom & $urandom) : 8'($urandom);
      cycle(r, $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
